ledflow_multi: RTL and testbench

Parametrised successor to the single-pattern 4-LED flow block. It drives LED_NUM LEDs from a prescaled step tick and offers four run-time modes: rotate up, rotate down, bounce and blink all. It also has a run-time speed select, an enable/pause input and a selectable output polarity. It sits between the board clock and the LED pins, and exposes the current position and the step pulse for debug or chaining.

---
 rtl/ledflow_multi.sv | 116 +++++++++++
 tb/tb_ledflow_multi.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ledflow_multi.sv
// ledflow_multi: multi-mode LED chaser driven by a prescaled step tick.
//   clk      system clock
//   rstn     synchronous reset, active HIGH despite the name
//   en_i     1 = run, 0 = freeze prescaler and pattern state
//   mode_i   0 ROT_UP, 1 ROT_DN, 2 BOUNCE, 3 BLINK (sampled on step edges)
//   speed_i  step period = max(CNT_MAX >> speed_i, 1) cycles
//   led_o    LED drive (registered), polarity per ACTIVE_LOW
//   pos_o    current lit position
//   step_o   combinational strobe, high in the cycle state advances
module ledflow_multi #(
  parameter int LED_NUM    = 8,
  parameter int CNT_MAX    = 50000000,
  parameter int CNT_W      = 26,
  parameter int ACTIVE_LOW = 1,
  localparam int PW        = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en_i,
  input  logic [1:0]         mode_i,
  input  logic [1:0]         speed_i,
  output logic [LED_NUM-1:0] led_o,
  output logic [PW-1:0]      pos_o,
  output logic               step_o
);

  typedef enum logic [1:0] {ROT_UP = 2'd0, ROT_DN = 2'd1, BOUNCE = 2'd2, BLINK = 2'd3} mode_e;

  localparam logic [31:0]         CMAX = 32'(CNT_MAX);
  localparam logic [PW-1:0]       LAST = PW'(LED_NUM - 1);
  localparam logic [LED_NUM-1:0]  DARK = (ACTIVE_LOW != 0) ? {LED_NUM{1'b1}} : '0;

  mode_e              mode;
  logic [CNT_W-1:0]   cnt;
  logic [PW-1:0]      pos, pos_n;
  logic               dir, dir_n;       // 1 = moving up
  logic               phase, phase_n;
  logic               run;
  logic [LED_NUM-1:0] led, pat, led_n;
  logic [31:0]        per_m1;

  assign mode = mode_e'(mode_i);

  // Period minus one; a shift that underflows to zero still gives a 1-cycle period.
  always_comb begin
    per_m1 = CMAX >> speed_i;
    if (per_m1 != 32'd0) per_m1 = per_m1 - 32'd1;
  end

  // >= so that shortening the period mid-count fires on the next cycle.
  assign step_o = en_i && (32'(cnt) >= per_m1);

  always_comb begin
    pos_n   = pos;
    dir_n   = dir;
    phase_n = phase;
    if (!run) begin
      // First step only makes the display live at pos 0.
      if (mode == BLINK) phase_n = 1'b1;
    end else begin
      case (mode)
        ROT_UP: begin
          phase_n = 1'b0;
          pos_n   = (pos == LAST) ? '0 : pos + PW'(1);
        end
        ROT_DN: begin
          phase_n = 1'b0;
          pos_n   = (pos == '0) ? LAST : pos - PW'(1);
        end
        BOUNCE: begin
          phase_n = 1'b0;
          // Reverse and move on the same step so ends are not shown twice.
          if (LED_NUM > 1) begin
            if (dir) begin
              if (pos == LAST) begin dir_n = 1'b0; pos_n = pos - PW'(1); end
              else pos_n = pos + PW'(1);
            end else begin
              if (pos == '0) begin dir_n = 1'b1; pos_n = pos + PW'(1); end
              else pos_n = pos - PW'(1);
            end
          end
        end
        default: phase_n = ~phase;
      endcase
    end
    pat = '0;
    for (int i = 0; i < LED_NUM; i++)
      pat[i] = (mode == BLINK) ? phase_n : (pos_n == PW'(i));
    led_n = (ACTIVE_LOW != 0) ? ~pat : pat;
  end

  // LED drive is registered so the pins only change on a step edge.
  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt   <= '0;
      pos   <= '0;
      dir   <= 1'b1;
      phase <= 1'b0;
      run   <= 1'b0;
      led   <= DARK;
    end else if (step_o) begin
      cnt   <= '0;
      pos   <= pos_n;
      dir   <= dir_n;
      phase <= phase_n;
      run   <= 1'b1;
      led   <= led_n;
    end else if (en_i) begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign led_o = led;
  assign pos_o = pos;

endmodule

// File: tb/tb_ledflow_multi.sv
// Bench for ledflow_multi with LED_NUM=4, CNT_MAX=4, ACTIVE_LOW=1.
// Step-level vector table plus hand sequences for speed switch, freeze and
// mid-run reset; expected step results go through a scoreboard queue.
module tb_ledflow_multi;

  logic       clk = 1'b0;
  logic       rstn, en_i;
  logic [1:0] mode_i, speed_i;
  logic [3:0] led_o;
  logic [1:0] pos_o;
  logic       step_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic [1:0] speed;
    int         n;
    logic [3:0] led;
    logic [1:0] pos;
  } vec_t;

  typedef struct {
    int         n;
    logic [3:0] led;
    logic [1:0] pos;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  ledflow_multi #(.LED_NUM(4), .CNT_MAX(4), .CNT_W(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rstn(rstn), .en_i(en_i), .mode_i(mode_i), .speed_i(speed_i),
    .led_o(led_o), .pos_o(pos_o), .step_o(step_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] m, input logic [1:0] s,
                     input int n, input logic [3:0] l, input logic [1:0] p);
    vec_t v;
    v.rst = r; v.mode = m; v.speed = s; v.n = n; v.led = l; v.pos = p;
    tbl.push_back(v);
  endtask

  task automatic push_exp(input int n, input logic [3:0] l, input logic [1:0] p);
    exp_t e;
    e.n = n; e.led = l; e.pos = p;
    exp_q.push_back(e);
  endtask

  // One reset edge with en_i high; leaves time at posedge+1.
  task automatic do_reset();
    rstn = 1'b1; en_i = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    chk("reset led", led_o, 4'hF);
    chk("reset pos", pos_o, 2'd0);
    chk("reset step", step_o, 1'b0);
  endtask

  // k clock cycles with no step expected.
  task automatic advance(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk); #1;
      chk("no step", step_o, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  // Waits for the next step, comparing against the front of the scoreboard.
  task automatic wait_step(input string nm);
    exp_t e;
    int n;
    bit got;
    logic [3:0] pl;
    logic [1:0] pp;
    if (exp_q.size() == 0) begin
      chk({nm, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    pl = led_o; pp = pos_o; n = 0; got = 1'b0;
    while (!got && n < 64) begin
      @(negedge clk); #1;
      n++;
      if (step_o) got = 1'b1;
      else begin
        chk({nm, " hold led"}, led_o, pl);
        chk({nm, " hold pos"}, pos_o, pp);
      end
    end
    chk({nm, " step seen"}, got, 1'b1);
    @(posedge clk); #1;
    if (got) chk({nm, " cycles"}, n, e.n);
    chk({nm, " led"}, led_o, e.led);
    chk({nm, " pos"}, pos_o, e.pos);
  endtask

  initial begin
    rstn = 1'b1; en_i = 1'b1; mode_i = 2'd0; speed_i = 2'd0;

    //  rst mode spd n  led      pos
    add(1, 0, 0, 4, 4'b1110, 0);
    add(0, 0, 0, 4, 4'b1101, 1);
    add(0, 0, 0, 4, 4'b1011, 2);
    add(0, 0, 0, 4, 4'b0111, 3);
    add(0, 0, 0, 4, 4'b1110, 0);
    add(0, 0, 0, 4, 4'b1101, 1);
    add(0, 0, 0, 4, 4'b1011, 2);
    add(0, 1, 0, 4, 4'b1101, 1);
    add(0, 1, 0, 4, 4'b1110, 0);
    add(0, 1, 0, 4, 4'b0111, 3);
    add(0, 1, 0, 4, 4'b1011, 2);
    add(0, 3, 0, 4, 4'b0000, 2);
    add(0, 3, 0, 4, 4'b1111, 2);
    add(0, 3, 0, 4, 4'b0000, 2);
    add(0, 0, 0, 4, 4'b0111, 3);
    add(1, 2, 0, 4, 4'b1110, 0);
    add(0, 2, 0, 4, 4'b1101, 1);
    add(0, 2, 0, 4, 4'b1011, 2);
    add(0, 2, 0, 4, 4'b0111, 3);
    add(0, 2, 0, 4, 4'b1011, 2);
    add(0, 2, 0, 4, 4'b1101, 1);
    add(0, 2, 0, 4, 4'b1110, 0);
    add(0, 2, 0, 4, 4'b1101, 1);
    add(0, 2, 1, 2, 4'b1011, 2);
    add(0, 2, 2, 1, 4'b0111, 3);
    add(0, 2, 3, 1, 4'b1011, 2);
    add(0, 0, 3, 1, 4'b0111, 3);
    add(0, 2, 0, 4, 4'b1011, 2);
    add(1, 3, 0, 4, 4'b0000, 0);
    add(0, 3, 0, 4, 4'b1111, 0);
    add(0, 1, 0, 4, 4'b0111, 3);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      mode_i = tbl[i].mode; speed_i = tbl[i].speed; en_i = 1'b1;
      push_exp(tbl[i].n, tbl[i].led, tbl[i].pos);
      wait_step($sformatf("vec%0d", i));
    end

    // Shortening the period while cnt is already past it fires next cycle.
    do_reset();
    mode_i = 2'd0; speed_i = 2'd0;
    advance(2);
    speed_i = 2'd1;
    push_exp(1, 4'b1110, 0);
    wait_step("speed switch");
    push_exp(2, 4'b1101, 1);
    wait_step("speed1");

    // Freeze with cnt at the step threshold: nothing moves, no strobe.
    speed_i = 2'd0;
    advance(3);
    en_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("freeze step", step_o, 1'b0);
      chk("freeze led", led_o, 4'b1101);
      chk("freeze pos", pos_o, 2'd1);
      @(posedge clk); #1;
    end
    en_i = 1'b1;
    push_exp(1, 4'b1011, 2);
    wait_step("resume");

    // Mid-count reset restarts cleanly at pos 0.
    advance(2);
    do_reset();
    push_exp(4, 4'b1110, 0);
    wait_step("post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
